// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one uart_tx serialiser
// between NREQ byte-stream requesters, with a stuck-transmitter timeout.
module uart_tx_arbiter #(
   parameter int NREQ           = 4,
   parameter int ACCEPT_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [8*NREQ-1:0]   req_data,
   input  logic [NREQ-1:0]     req_last,
   output logic [NREQ-1:0]     req_ack,
   output logic [NREQ-1:0]     grant,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   input  logic                tx_avl,
   output logic                busy,
   output logic                err_timeout,
   input  logic                err_clr
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(ACCEPT_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCEPT, DONE, HOLD} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   owner, owner_nxt;
   logic [IW-1:0]   ptr, ptr_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            last_r, last_nxt;
   logic [NREQ-1:0] grant_nxt, ack_nxt;
   logic            start_nxt, busy_nxt, err_nxt, set_err;
   logic [7:0]      data_nxt;
   logic            do_issue, do_release;
   logic [IW-1:0]   issue_idx;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
      return NREQ'(1) << i;
   endfunction

   // First valid requester scanning ptr, ptr+1, ... with wrap-around.
   function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] v,
                                          input logic [IW-1:0]   p);
      logic [IW-1:0] idx;
      logic          found;
      pick  = p;
      idx   = p;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && v[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = next_idx(idx);
      end
   endfunction

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      ptr_nxt    = ptr;
      cnt_nxt    = cnt;
      last_nxt   = last_r;
      grant_nxt  = grant;
      ack_nxt    = '0;
      start_nxt  = 1'b0;
      data_nxt   = tx_data;
      set_err    = 1'b0;
      do_issue   = 1'b0;
      do_release = 1'b0;
      issue_idx  = owner;

      case (state)
         IDLE: begin
            if ((|req_valid) && tx_avl) begin
               do_issue  = 1'b1;
               issue_idx = pick(req_valid, ptr);
            end
         end
         ACCEPT: begin
            // uart_tx registers write_avl, so the first ACCEPT cycle still sees it high.
            if (!tx_avl) begin
               ack_nxt   = onehot(owner);
               state_nxt = DONE;
            end else if (cnt == CW'(ACCEPT_TIMEOUT - 1)) begin
               set_err    = 1'b1;
               do_release = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE: begin
            if (tx_avl) begin
               if (last_r) do_release = 1'b1;
               else        state_nxt  = HOLD;
            end
         end
         HOLD: begin
            // Other requesters are ignored; an owner dropping valid forfeits the lock.
            if (!req_valid[owner]) begin
               do_release = 1'b1;
            end else if (tx_avl) begin
               do_issue  = 1'b1;
               issue_idx = owner;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (do_issue) begin
         owner_nxt = issue_idx;
         grant_nxt = onehot(issue_idx);
         data_nxt  = req_data[8*issue_idx +: 8];
         last_nxt  = req_last[issue_idx];
         start_nxt = 1'b1;
         cnt_nxt   = '0;
         state_nxt = ACCEPT;
      end
      if (do_release) begin
         grant_nxt = '0;
         ptr_nxt   = next_idx(owner);
         state_nxt = IDLE;
      end

      err_nxt  = set_err | (err_timeout & ~err_clr);
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state       <= IDLE;
         owner       <= '0;
         ptr         <= '0;
         cnt         <= '0;
         last_r      <= 1'b0;
         grant       <= '0;
         req_ack     <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         ptr         <= ptr_nxt;
         cnt         <= cnt_nxt;
         last_r      <= last_nxt;
         grant       <= grant_nxt;
         req_ack     <= ack_nxt;
         tx_start    <= start_nxt;
         tx_data     <= data_nxt;
         busy        <= busy_nxt;
         err_timeout <= err_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: a packet-level round-robin model
// predicts the transmitted byte order, and a simple uart_tx model drives tx_avl.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int TO   = 16;

   logic                clk = 1'b0;
   logic                n_reset = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [8*NREQ-1:0]   req_data = '0;
   logic [NREQ-1:0]     req_last = '0;
   logic [NREQ-1:0]     req_ack;
   logic [NREQ-1:0]     grant;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                tx_avl;
   logic                busy;
   logic                err_timeout;
   logic                err_clr = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(NREQ), .ACCEPT_TIMEOUT(TO)) dut (
      .clk(clk), .n_reset(n_reset),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ack(req_ack), .grant(grant),
      .tx_start(tx_start), .tx_data(tx_data), .tx_avl(tx_avl),
      .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         frame    = 3;
   bit         stuck    = 1'b0;
   int         mdl_ptr  = 0;
   int         ack_cnt  = 0;
   bit [8:0]   rq [NREQ][$];      // per requester: {last, data}
   bit [11:0]  txlog[$];          // observed {grant, data} at each tx_start
   bit [11:0]  exp_log[$];

   task automatic check_eq(string tag, logic [31:0] got, logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // uart_tx stand-in: registered write_avl, low for 'frame' cycles per byte.
   initial begin
      bit st;
      int bcnt;
      tx_avl = 1'b1;
      bcnt   = 0;
      forever begin
         @(negedge clk);
         st = tx_start;
         @(posedge clk);
         #1;
         if (!n_reset) begin
            tx_avl = 1'b1;
            bcnt   = 0;
         end else if (st && !stuck) begin
            tx_avl = 1'b0;
            bcnt   = frame;
         end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) tx_avl = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit any_pending();
      for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      @(negedge clk);
      if (tx_start) txlog.push_back({grant, tx_data});
      if (req_ack != '0) begin
         ack_cnt++;
         check_eq("ack_onehot", 32'($onehot(req_ack)), 1);
         check_eq("ack_owner", 32'(req_ack), 32'(grant));
         for (int i = 0; i < NREQ; i++)
            if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]        = rq[i][0][8];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
   endtask

   task automatic step();
      tick();
      drive();
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      drive();
      repeat (3) @(negedge clk);
      txlog.delete();
      mdl_ptr = 0;
      n_reset = 1'b1;
   endtask

   // Packet-level round robin: whole packet (until last, or until the owner
   // runs dry) goes to the first non-empty requester from the pointer.
   task automatic model_predict();
      bit [8:0] cp [NREQ][$];
      bit [8:0] e;
      int       w;
      for (int i = 0; i < NREQ; i++) cp[i] = rq[i];
      exp_log.delete();
      txlog.delete();
      forever begin
         w = -1;
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && cp[(mdl_ptr + k) % NREQ].size() > 0) w = (mdl_ptr + k) % NREQ;
         if (w < 0) break;
         do begin
            e = cp[w].pop_front();
            exp_log.push_back({4'(1 << w), e[7:0]});
         end while (!e[8] && cp[w].size() > 0);
         mdl_ptr = (w + 1) % NREQ;
      end
   endtask

   task automatic compare_log(string tag);
      int n;
      check_eq({tag, "_count"}, txlog.size(), exp_log.size());
      n = (txlog.size() < exp_log.size()) ? txlog.size() : exp_log.size();
      for (int k = 0; k < n; k++) check_eq({tag, "_byte"}, 32'(txlog[k]), 32'(exp_log[k]));
   endtask

   task automatic drain(string tag, int budget);
      int n = 0;
      step();
      while ((any_pending() || busy) && n < budget) begin
         step();
         n++;
      end
      check_eq({tag, "_drained"}, 32'(n < budget), 1);
      repeat (2) step();
   endtask

   task automatic run_case(string tag);
      model_predict();
      drive();
      drain(tag, 3000);
      compare_log(tag);
   endtask

   initial begin
      int a0, n;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_grant", 32'(grant), 0);
      check_eq("rst_ack", 32'(req_ack), 0);
      check_eq("rst_start", 32'(tx_start), 0);
      check_eq("rst_data", 32'(tx_data), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_err", 32'(err_timeout), 0);
      do_reset();

      // 1: single requester, then pointer-relative order
      rq[1].push_back({1'b1, 8'h55});
      model_predict();
      drive();
      tick();
      check_eq("t1_start", 32'(tx_start), 1);
      check_eq("t1_data", 32'(tx_data), 32'h55);
      check_eq("t1_grant", 32'(grant), 32'b0010);
      check_eq("t1_busy", 32'(busy), 1);
      drive();
      step();
      check_eq("t1_pulse", 32'(tx_start), 0);
      a0 = ack_cnt;
      n  = 0;
      while (ack_cnt == a0 && n < 50) begin
         step();
         n++;
      end
      check_eq("t1_ack", 32'(req_ack), 32'b0010);
      drain("t1", 100);
      check_eq("t1_release", 32'(grant), 0);
      compare_log("t1");
      rq[0].push_back({1'b1, 8'h30});
      rq[2].push_back({1'b1, 8'h32});
      run_case("t1_ptr");

      // 2: round robin over all four, then re-request 2 and 0
      do_reset();
      for (int i = 0; i < NREQ; i++) rq[i].push_back({1'b1, 8'(8'hA0 + i)});
      run_case("t2_all");
      rq[2].push_back({1'b1, 8'hB2});
      rq[0].push_back({1'b1, 8'hB0});
      run_case("t2_re");

      // 3: packet lock against a competing requester
      do_reset();
      rq[0].push_back({1'b0, 8'h10});
      rq[0].push_back({1'b0, 8'h11});
      rq[0].push_back({1'b1, 8'h12});
      rq[1].push_back({1'b1, 8'h20});
      run_case("t3_lock");

      // 4: owner drops valid mid-packet
      do_reset();
      rq[0].push_back({1'b0, 8'h40});
      rq[2].push_back({1'b1, 8'h42});
      run_case("t4_drop");

      // Randomised packet mixes with varying frame time
      for (int r = 0; r < 20; r++) begin
         frame = $urandom_range(1, 6);
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               int npk;
               npk = $urandom_range(1, 2);
               for (int p = 0; p < npk; p++) begin
                  int len;
                  bit drop;
                  len  = $urandom_range(1, 3);
                  drop = (p == npk - 1) && ($urandom_range(0, 5) == 0);
                  for (int b = 0; b < len; b++)
                     rq[i].push_back({(b == len - 1) && !drop, 8'($urandom)});
               end
            end
         end
         run_case("rand");
      end
      frame = 3;

      // 5: timeout, clear, and set-wins-over-clear
      do_reset();
      stuck = 1'b1;
      a0 = ack_cnt;
      rq[1].push_back({1'b1, 8'h77});
      drive();
      tick();
      check_eq("t5_start", 32'(tx_start), 1);
      drive();
      repeat (TO - 1) step();
      check_eq("t5_err_early", 32'(err_timeout), 0);
      tick();
      check_eq("t5_err", 32'(err_timeout), 1);
      check_eq("t5_grant", 32'(grant), 0);
      check_eq("t5_busy", 32'(busy), 0);
      rq[1].delete();
      drive();
      check_eq("t5_no_ack", ack_cnt, a0);
      tick();
      err_clr = 1'b1;
      drive();
      tick();
      check_eq("t5_clr", 32'(err_timeout), 0);
      rq[2].push_back({1'b1, 8'h78});
      drive();
      tick();
      check_eq("t5_start2", 32'(tx_start), 1);
      drive();
      repeat (TO - 1) step();
      tick();
      check_eq("t5_set_wins", 32'(err_timeout), 1);
      rq[2].delete();
      err_clr = 1'b0;
      drive();
      tick();
      check_eq("t5_sticky", 32'(err_timeout), 1);
      check_eq("t5_no_ack2", ack_cnt, a0);
      stuck = 1'b0;

      // 6: asynchronous reset while in DONE
      do_reset();
      rq[1].push_back({1'b1, 8'h5A});
      drive();
      a0 = ack_cnt;
      n  = 0;
      while (ack_cnt == a0 && n < 50) begin
         step();
         n++;
      end
      check_eq("t6_in_done", 32'(busy), 1);
      #2;
      n_reset = 1'b0;
      #1;
      check_eq("t6_grant", 32'(grant), 0);
      check_eq("t6_ack", 32'(req_ack), 0);
      check_eq("t6_start", 32'(tx_start), 0);
      check_eq("t6_data", 32'(tx_data), 0);
      check_eq("t6_busy", 32'(busy), 0);
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      drive();
      repeat (2) @(negedge clk);
      txlog.delete();
      mdl_ptr = 0;
      n_reset = 1'b1;
      rq[3].push_back({1'b1, 8'hC3});
      rq[1].push_back({1'b1, 8'hC1});
      run_case("t6_resume");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
